// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Groups the PLL supervision signals of pll_reset_sequencer.
//   master : board/PLL side, drives pll_locked and restart_req, observes the rest.
//   slave  : the sequencer itself.
// Signals:
//   pll_locked    PLL LOCK output, asynchronous to the reference clock
//   restart_req   single-cycle pulse requesting a full PLL restart
//   pll_resetb    to PLL RESETB, 0 holds the PLL in reset
//   cpu_reset_n   active-low core reset
//   ready         1 only in RUN, identical to cpu_reset_n
//   state         0 PLL_RESET, 1 WAIT_LOCK, 2 RELEASE, 3 RUN
//   lock_loss_cnt saturating count of lock losses in RELEASE/RUN
//   timeout_cnt   saturating count of WAIT_LOCK timeouts
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_resetb;
    logic       cpu_reset_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;
    logic [7:0] timeout_cnt;

    modport master (
        output pll_locked, restart_req,
        input  pll_resetb, cpu_reset_n, ready, state, lock_loss_cnt, timeout_cnt
    );

    modport slave (
        input  pll_locked, restart_req,
        output pll_resetb, cpu_reset_n, ready, state, lock_loss_cnt, timeout_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the iCE40 PLL and sequences the CPU core reset. Runs on the
//   16 MHz reference clock, never on the PLL output.
//   Holds the PLL in reset, waits for a debounced LOCK (with timeout/retry),
//   waits a settling delay, then releases the core. Loss of lock or a restart
//   request sends it back to PLL reset.
// Ports:
//   clock_in  16 MHz reference clock
//   reset_n   asynchronous active-low reset of this block
//   bus       pll_reset_sequencer_if.slave (lock/restart in, resets/status out)
module pll_reset_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_STABLE   = 256,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned RELEASE_DELAY = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    pll_reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StPllReset = 2'd0,
        StWaitLock = 2'd1,
        StRelease  = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ResetLast   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_DELAY - 1);

    // LOCK is asynchronous to clock_in; only locked_s is used beyond this point.
    logic sync_q;
    logic locked_s;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= bus.pll_locked;
            locked_s <= sync_q;
        end
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] stable_q;
    logic             pll_resetb_q;
    logic             cpu_reset_n_q;
    logic [7:0]       lock_loss_q;
    logic [7:0]       timeout_q;
    logic             lock_lost;
    logic             timed_out;

    // Next-state decode. cyc_q is the per-state cycle counter (reset hold,
    // lock timeout, release delay); it is cleared on every state change.
    always_comb begin
        state_d   = state_q;
        lock_lost = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            StPllReset: begin
                // restart_req is deliberately ignored here
                if (cyc_q == ResetLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (bus.restart_req) begin
                    state_d = StPllReset;
                end else if (locked_s && (stable_q == StableLast)) begin
                    // lock qualification wins over a coincident timeout
                    state_d = StRelease;
                end else if (cyc_q == TimeoutLast) begin
                    state_d   = StPllReset;
                    timed_out = 1'b1;
                end
            end
            StRelease: begin
                if (!locked_s) begin
                    state_d   = StPllReset;
                    lock_lost = 1'b1;
                end else if (bus.restart_req) begin
                    state_d = StPllReset;
                end else if (cyc_q == ReleaseLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // a lock loss coincident with restart_req is counted as a loss
                if (!locked_s) begin
                    state_d   = StPllReset;
                    lock_lost = 1'b1;
                end else if (bus.restart_req) begin
                    state_d = StPllReset;
                end
            end
            default: state_d = StPllReset;
        endcase
    end

    // State, counters and registered outputs. Outputs are decoded from
    // state_d so they change on the same edge as the state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StPllReset;
            cyc_q         <= '0;
            stable_q      <= '0;
            pll_resetb_q  <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            lock_loss_q   <= 8'd0;
            timeout_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            pll_resetb_q  <= (state_d != StPllReset);
            cpu_reset_n_q <= (state_d == StRun);

            if (state_d != state_q) begin
                cyc_q    <= '0;
                stable_q <= '0;
            end else begin
                if (state_q != StRun) begin
                    cyc_q <= cyc_q + 1'b1;
                end
                if (state_q == StWaitLock) begin
                    stable_q <= locked_s ? stable_q + 1'b1 : '0;
                end
            end

            if (lock_lost && (lock_loss_q != 8'hFF)) begin
                lock_loss_q <= lock_loss_q + 8'd1;
            end
            if (timed_out && (timeout_q != 8'hFF)) begin
                timeout_q <= timeout_q + 8'd1;
            end
        end
    end

    assign bus.pll_resetb    = pll_resetb_q;
    assign bus.cpu_reset_n   = cpu_reset_n_q;
    assign bus.ready         = cpu_reset_n_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = lock_loss_q;
    assign bus.timeout_cnt   = timeout_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the iCE40 PLL (16 MHz reference in, 40 MHz core clock out) and sequences reset for the CPU core.
- Drives the PLL RESETB pin.
- Waits for a stable, debounced LOCK, with a timeout and retry.
- Releases the core reset only after a settling delay.
- Re-asserts core reset and restarts the PLL on loss of lock or on a restart request.
- Runs on the always-present 16 MHz reference clock, never on the PLL output.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low per PLL reset attempt (>=1).
LOCK_STABLE, 256, consecutive cycles synchronized lock must be high before release (>=1).
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before retrying a PLL reset (> LOCK_STABLE).
RELEASE_DELAY, 16, cycles between lock qualification and core reset deassertion (>=1).
CNT_W, 16, width of the shared internal cycle counters; must hold LOCK_TIMEOUT.

Ports:
clock_in  input  1  16 MHz reference clock (same net as the PLL REFERENCECLK).
reset_n  input  1  asynchronous, active-low reset of this block.
pll_locked  input  1  PLL LOCK output; asynchronous to clock_in.
restart_req  input  1  synchronous to clock_in, single-cycle pulse requesting a full PLL restart.
pll_resetb  output  1  to PLL RESETB; 0 holds the PLL in reset.
cpu_reset_n  output  1  active-low core reset; the consumer synchronizes deassertion into the 40 MHz domain.
ready  output  1  1 only in RUN; identical to cpu_reset_n.
state  output  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 RELEASE, 3 RUN.
lock_loss_cnt  output  8  saturating count of lock losses seen in RELEASE or RUN.
timeout_cnt  output  8  saturating count of WAIT_LOCK timeouts.

Behaviour:
Reset (reset_n=0, asynchronous):
- state=PLL_RESET, pll_resetb=0, cpu_reset_n=0, ready=0.
- All counters = 0; both lock synchronizer flops = 0.
- Reset applied mid-operation aborts immediately to these values.

Lock input:
- pll_locked passes through a 2-FF synchronizer, producing locked_s. Only locked_s is used.
- Latency from pll_locked to locked_s is 2 cycles.

Outputs:
- All outputs are registered and derived from the next state, so each changes on the same edge the state changes.
- pll_resetb = 0 only in PLL_RESET.
- cpu_reset_n = ready = 1 only in RUN.

FSM:
- PLL_RESET: cycle counter counts up. After RESET_CYCLES cycles in this state go to WAIT_LOCK and clear the counters. After reset_n deasserts, pll_resetb is low for exactly RESET_CYCLES cycles.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - Stable counter increments while locked_s=1 and clears on any locked_s=0.
  - If locked_s=1 and stable counter = LOCK_STABLE-1, go to RELEASE.
  - Otherwise, if timeout counter = LOCK_TIMEOUT-1, go to PLL_RESET and increment timeout_cnt.
  - If both conditions are true in the same cycle, RELEASE wins.
- RELEASE: counts RELEASE_DELAY cycles, then goes to RUN. If locked_s=0 in any cycle, go to PLL_RESET and increment lock_loss_cnt.
- RUN: stays while locked_s=1. If locked_s=0, go to PLL_RESET and increment lock_loss_cnt. cpu_reset_n drops on the same edge as the transition, i.e. 2-3 cycles after pll_locked falls.

Restart:
- restart_req=1 in WAIT_LOCK, RELEASE or RUN: go to PLL_RESET with no counter increment.
- restart_req is ignored in PLL_RESET.
- If lock loss and restart_req occur in the same cycle, it is counted as a lock loss.

Counters and timing:
- lock_loss_cnt and timeout_cnt saturate at 255 and never wrap. They are cleared only by reset_n.
- Internal counters clear on every state change.
- Nominal latency from pll_locked rising (stable, with state already WAIT_LOCK) to cpu_reset_n rising is 2 + LOCK_STABLE + RELEASE_DELAY cycles.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RELEASE_DELAY=4.
1. Power-up: release reset_n, then raise pll_locked at cycle 10 -> pll_resetb low cycles 0-3, high from 4; state reaches RUN and cpu_reset_n=1 at cycle 24; both counters 0.
2. Glitchy lock: in WAIT_LOCK, pll_locked high 5 cycles, low 1, then high -> stable counter restarts; cpu_reset_n rises 14 cycles after the final rising edge.
3. Timeout: pll_locked held 0 -> returns to PLL_RESET every 36 cycles (4+32); timeout_cnt increments 1, 2, 3; cpu_reset_n stays 0.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> cpu_reset_n=0 within 3 cycles; state=0; lock_loss_cnt=1; full sequence repeats.
5. restart_req pulse in RUN, and restart_req coincident with lock loss -> first: PLL_RESET with counters unchanged; second: lock_loss_cnt increments by exactly 1.
6. Saturation and reset: force 300 timeouts -> timeout_cnt=255. Assert reset_n mid-RELEASE -> all outputs reach reset values asynchronously.
